// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: accepts an ALU operation request, runs count back-to-back passes
// through the external combinational ALU with the result fed back into A, and returns
// the final accumulator and flags over a result handshake.
module alu_op_sequencer #(
   parameter int unsigned N      = 8,
   parameter int unsigned FUNC_W = 4,
   parameter int unsigned CNT_W  = 4,
   parameter int unsigned FLAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [FUNC_W-1:0] req_func,
   input  logic [N-1:0]      req_a,
   input  logic [N-1:0]      req_b,
   input  logic [CNT_W-1:0]  req_count,
   output logic [N-1:0]      alu_a,
   output logic [N-1:0]      alu_b,
   output logic [FUNC_W-1:0] alu_func,
   input  logic [N-1:0]      alu_result,
   input  logic [FLAG_W-1:0] alu_flags,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [N-1:0]      res_data,
   output logic [FLAG_W-1:0] res_flags,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [N-1:0]      acc_q, acc_d;
   logic [N-1:0]      b_q, b_d;
   logic [FUNC_W-1:0] func_q, func_d;
   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [FLAG_W-1:0] flags_q, flags_d;
   logic              accept;

   assign accept = req_valid & req_ready;

   // State register; reset abandons any operation in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: zero-pass requests skip EXEC; last pass is when one remains.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               state_d = (req_count == CNT_W'(0)) ? S_DONE : S_EXEC;
            end
         end
         S_EXEC: begin
            if (rem_q == CNT_W'(1)) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (res_ready) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath next values: latch request on accept, feed ALU result back each pass.
   always_comb begin
      acc_d   = acc_q;
      b_d     = b_q;
      func_d  = func_q;
      rem_d   = rem_q;
      flags_d = flags_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               acc_d   = req_a;
               b_d     = req_b;
               func_d  = req_func;
               rem_d   = req_count;
               flags_d = '0;
            end
         end
         S_EXEC: begin
            acc_d   = alu_result;
            flags_d = alu_flags;
            rem_d   = rem_q - CNT_W'(1);
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q   <= '0;
         b_q     <= '0;
         func_q  <= '0;
         rem_q   <= '0;
         flags_q <= '0;
      end else begin
         acc_q   <= acc_d;
         b_q     <= b_d;
         func_q  <= func_d;
         rem_q   <= rem_d;
         flags_q <= flags_d;
      end
   end

   // Output decode: ALU inputs quiet outside EXEC, result only presented in DONE.
   always_comb begin
      req_ready = 1'b0;
      alu_a     = '0;
      alu_b     = '0;
      alu_func  = '0;
      res_valid = 1'b0;
      res_data  = '0;
      res_flags = '0;
      busy      = 1'b0;
      case (state_q)
         S_IDLE: begin
            req_ready = ~rst;
         end
         S_EXEC: begin
            alu_a    = acc_q;
            alu_b    = b_q;
            alu_func = func_q;
            busy     = 1'b1;
         end
         S_DONE: begin
            res_valid = 1'b1;
            res_data  = acc_q;
            res_flags = flags_q;
            busy      = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
